// File: rtl/sram_2p_masked.sv
`default_nettype none
// ============================================================================
// Module      : sram_2p_masked
// Description : One-clock RAM with a masked read/write port 0, a read-only
//               port 1, and a hardware init sweep that gates ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_2p_masked #(
    parameter int                    DATA_WIDTH = 256,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    MASK_GRAN  = 8,
    localparam int                   NUM_WMASKS = DATA_WIDTH / MASK_GRAN,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter bit                    BYPASS     = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    output logic                  ready,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    localparam int                    c_RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [DATA_WIDTH-1:0] r_mem [c_RAM_DEPTH];

    logic [DATA_WIDTH-1:0] w_bitmask;
    logic [DATA_WIDTH-1:0] w_old0;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_run;
    logic                  w_wr0;
    logic                  w_collide;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WMASKS; gi++) begin : g_lane
            assign w_bitmask[gi*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask0[gi]}};
        end
    endgenerate

    // The merged word feeds the array, the port 0 write-first output and the port 1 bypass.
    assign w_old0    = r_mem[addr0];
    assign w_merged  = (w_old0 & ~w_bitmask) | (din0 & w_bitmask);
    assign w_run     = (r_state == S_RUN);
    assign w_wr0     = w_run && !csb0 && !web0;
    assign w_collide = w_wr0 && !csb1 && (addr1 == addr0);

    always_ff @(posedge clk0) begin : p_ctrl
        if (rst0) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            ready      <= 1'b0;
            dout0      <= '0;
            dout1      <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == c_LAST_ADDR) begin
                        r_state <= S_RUN;
                        ready   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!csb0) begin
                        dout0 <= web0 ? w_old0 : w_merged;
                    end
                    if (!csb1) begin
                        dout1 <= (BYPASS && w_collide) ? w_merged : r_mem[addr1];
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Storage has no reset of its own; the sweep is what brings it to a known state.
    always_ff @(posedge clk0) begin : p_mem
        if (!rst0) begin
            if (r_state == S_INIT) begin
                r_mem[r_init_cnt] <= INIT_VALUE;
            end else if (w_wr0) begin
                r_mem[addr0] <= w_merged;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_2p_masked.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_2p_masked
// Description : Scoreboard bench running BYPASS=1 and BYPASS=0 copies in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_2p_masked;

    localparam int             DW    = 256;
    localparam int             AW    = 4;
    localparam int             MG    = 8;
    localparam int             NW    = DW / MG;
    localparam int             DEPTH = 1 << AW;
    localparam logic [DW-1:0]  INITV = {32{8'hA5}};

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          csb0, web0, csb1;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;
    logic          ready_a, ready_b;
    logic [DW-1:0] dout0_a, dout1_a, dout0_b, dout1_b;

    always #5 clk0 = ~clk0;

    sram_2p_masked #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(MG), .INIT_VALUE(INITV), .BYPASS(1'b1)
    ) u_dut_byp (
        .clk0(clk0), .rst0(rst0), .ready(ready_a), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0_a),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a)
    );

    sram_2p_masked #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(MG), .INIT_VALUE(INITV), .BYPASS(1'b0)
    ) u_dut_old (
        .clk0(clk0), .rst0(rst0), .ready(ready_b), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0_b),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b)
    );

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1_new;
        logic [DW-1:0] d1_old;
        logic          rdy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: array contents, expected outputs, and sweep progress.
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] m_d0, m_d1_new, m_d1_old;
    logic          m_rdy;
    bit            m_init;
    int            m_pos;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input logic rst, input logic c0, input logic w0, input logic [NW-1:0] m,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d,
                        input logic c1, input logic [AW-1:0] a1);
        logic [DW-1:0] old0, old1, merged;
        exp_t e;
        rst0 = rst; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
        csb1 = c1; addr1 = a1;
        if (rst) begin
            m_rdy = 1'b0; m_d0 = '0; m_d1_new = '0; m_d1_old = '0;
            m_init = 1'b1; m_pos = 0;
        end else if (m_init) begin
            mm[m_pos] = INITV;
            m_pos++;
            if (m_pos == DEPTH) begin
                m_init = 1'b0;
                m_rdy  = 1'b1;
            end
        end else begin
            old0   = mm[a0];
            old1   = mm[a1];
            merged = old0;
            for (int i = 0; i < NW; i++)
                if (m[i]) merged[i*MG +: MG] = d[i*MG +: MG];
            if (!c0) m_d0 = w0 ? old0 : merged;
            if (!c1) begin
                m_d1_old = old1;
                m_d1_new = (!c0 && !w0 && a1 == a0) ? merged : old1;
            end
            if (!c0 && !w0) mm[a0] = merged;
        end
        e.d0 = m_d0; e.d1_new = m_d1_new; e.d1_old = m_d1_old; e.rdy = m_rdy;
        @(posedge clk0);
        q.push_back(e);
        #1;
    endtask

    task automatic idle_rand(input logic rst);
        step(rst, 1'($urandom), 1'($urandom), NW'($urandom), AW'($urandom), rnd_word(),
             1'($urandom), AW'($urandom));
    endtask

    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk0);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk_bit("ready_byp", ready_a, e.rdy);
                chk_bit("ready_old", ready_b, e.rdy);
                chk_word("dout0_byp", dout0_a, e.d0);
                chk_word("dout0_old", dout0_b, e.d0);
                chk_word("dout1_byp", dout1_a, e.d1_new);
                chk_word("dout1_old", dout1_b, e.d1_old);
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        logic [AW-1:0] a0, a1;
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; addr1 = '0;

        // Init sweep with noise on the ignored inputs.
        repeat (2) idle_rand(1'b1);
        repeat (DEPTH) idle_rand(1'b0);
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 1, '0, AW'(DEPTH - 1 - a), '0, 0, AW'(a));

        // Single-lane masked write.
        step(0, 0, 0, NW'(1), 4'd3, {32{8'hFF}}, 1, '0);
        step(0, 0, 1, '0, 4'd3, '0, 0, 4'd3);

        // Same-cycle write/read collision, then a clean read.
        step(0, 0, 0, '1, 4'd5, {8{32'h12345678}}, 0, 4'd5);
        step(0, 1, 1, '0, 4'd0, '0, 0, 4'd5);

        // Independent reads after seeding two locations.
        step(0, 0, 0, '1, 4'd2, rnd_word(), 1, '0);
        step(0, 0, 0, '1, 4'd7, rnd_word(), 1, '0);
        step(0, 0, 1, '0, 4'd2, '0, 0, 4'd7);

        // Hold with toggling addresses and data.
        for (int i = 0; i < 3; i++)
            step(0, 1, 1'($urandom), NW'($urandom), AW'(i * 5), rnd_word(), 1, AW'(15 - i));

        // Random traffic with frequent collisions.
        for (int i = 0; i < 300; i++) begin
            a0 = AW'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom);
            step(0, 1'($urandom_range(0, 3) == 0), 1'($urandom), NW'($urandom), a0, rnd_word(),
                 1'($urandom_range(0, 3) == 0), a1);
        end

        // Reset during RUN, then again at sweep counter 7.
        for (int i = 0; i < 4; i++) step(0, 0, 0, '1, AW'(i * 3), rnd_word(), 1, '0);
        idle_rand(1'b1);
        repeat (7) idle_rand(1'b0);
        idle_rand(1'b1);
        repeat (DEPTH) idle_rand(1'b0);
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 1, '0, AW'(a), '0, 0, AW'(DEPTH - 1 - a));

        csb0 = 1'b1; csb1 = 1'b1;
        repeat (3) @(negedge clk0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_2p_masked.md
Name: sram_2p_masked

Overview:
- Parametrised successor to the single-port masked SRAM models used for cache data and tag arrays.
- Two ports on one clock:
  - Port 0 is read/write with a configurable write-mask granularity.
  - Port 1 is read-only.
- Adds a synchronous reset, a hardware init sweep that loads INIT_VALUE into every word, a ready flag, and configurable port-1 read-during-write forwarding.
- Drop-in storage for cache data/tag/valid arrays that must come up in a known state.

Parameters:
- DATA_WIDTH, 256, word width in bits; must be a multiple of MASK_GRAN.
- ADDR_WIDTH, 4, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- MASK_GRAN, 8, bits per write-mask lane.
- NUM_WMASKS, DATA_WIDTH/MASK_GRAN, number of mask lanes; derived, not overridden.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during the init sweep.
- BYPASS, 1, port 1 read-during-write behaviour:
  - 1: port 1 returns the merged new data.
  - 0: port 1 returns the old data.

Ports:
- clk0  in  1  clock; all state updates on posedge.
- rst0  in  1  synchronous active-high reset.
- ready  out  1  high once the init sweep has completed.
- csb0  in  1  port 0 active-low chip select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  NUM_WMASKS  port 0 lane write mask; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- csb1  in  1  port 1 active-low chip select.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.

Behaviour:
- Reset, sampled at posedge with rst0=1:
  - FSM goes to INIT and the init counter goes to 0.
  - ready=0, dout0=0, dout1=0.
  - No memory write other than the init sweep occurs in that cycle.
- INIT state:
  - Each posedge writes INIT_VALUE to mem[counter] and increments the counter.
  - At counter == RAM_DEPTH-1 the write completes and the FSM moves to RUN.
  - ready rises on the following cycle, exactly RAM_DEPTH cycles after rst0 deasserts.
  - csb0, csb1, web0 are ignored and dout0/dout1 hold 0.
- RUN state: ready=1 and normal access. Only rst0 leaves RUN.
- Reset mid-sweep restarts the sweep from address 0.
- Port 0 write (csb0=0, web0=0):
  - At posedge, lanes with wmask0[i]=1 take din0; the other lanes are unchanged.
  - wmask0 all zero leaves memory unchanged.
  - dout0 updates the same posedge to the merged new word (write-first), visible 1 cycle after the request.
- Port 0 read (csb0=0, web0=1): dout0 <= mem[addr0] at posedge, 1-cycle latency.
- Port 1 read (csb1=0): dout1 <= mem[addr1] at posedge, 1-cycle latency.
- csb=1 on a port: that port's dout holds its previous value and nothing is written.
- Collision, port 1 reading the address port 0 writes in the same cycle:
  - BYPASS=1: dout1 = merged new word.
  - BYPASS=0: dout1 = pre-write word.
- Outputs are registered; there is no combinational path from inputs to dout.
- Behaviour for unknown (X) addresses is not guaranteed.

Test Plan:
- Init sweep:
  - Stimulus: rst0 high for 2 cycles, then low; INIT_VALUE=0xA5 repeated.
  - Required: ready rises exactly 16 cycles later; port 1 reads of addresses 0..15 all return INIT_VALUE.
- Masked write:
  - Stimulus: write addr 3, din0 all 0xFF, wmask0=0x0000_0001; then read addr 3.
  - Required: byte 0 = 0xFF, all other bytes = INIT_VALUE.
- Dual-port same cycle:
  - Stimulus: port 0 writes addr 5 full mask with 0x1234...; port 1 reads addr 5 in the same cycle.
  - Required: BYPASS=1 gives the new word; BYPASS=0 rebuild gives the old word; a second port 1 read gives the new word in both cases.
- Independent read:
  - Stimulus: port 0 reads addr 2 while port 1 reads addr 7.
  - Required: both douts are valid 1 cycle later with their respective contents.
- Hold behaviour:
  - Stimulus: after a read, csb0=csb1=1 for 3 cycles while addresses toggle.
  - Required: dout0 and dout1 are unchanged.
- Reset mid-operation:
  - Stimulus: assert rst0 at sweep counter 7, after earlier RUN writes.
  - Required: ready=0, douts=0, sweep restarts at address 0, ready again after 16 cycles, and all words equal INIT_VALUE (prior writes erased).
